// File: rtl/ofdm_preamble_pkg.sv
// Shared preamble definitions: FSM states, segment lengths, sample type and the STS/LTS ROMs.
// ROM values are the 802.11a time-domain training symbols x4 gain in Q1.6, rounded to nearest.
package ofdm_preamble_pkg;

  localparam int STS_LEN  = 16;
  localparam int LTS_LEN  = 64;
  localparam int SAMPLE_W = 8;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_STS  = 3'd1,
    ST_GI2  = 3'd2,
    ST_LTS  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic SEG_STS = 1'b0;
  localparam logic SEG_LTS = 1'b1;

  localparam sample_t STS_RE [STS_LEN] = '{
    8'sd12, -8'sd34, -8'sd3, 8'sd37, 8'sd24, 8'sd37, -8'sd3, -8'sd34,
    8'sd12, 8'sd1, -8'sd20, -8'sd3, 8'sd0, -8'sd3, -8'sd20, 8'sd1};
  localparam sample_t STS_IM [STS_LEN] = '{
    8'sd12, 8'sd1, -8'sd20, -8'sd3, 8'sd0, -8'sd3, -8'sd20, 8'sd1,
    8'sd12, -8'sd34, -8'sd3, 8'sd37, 8'sd24, 8'sd37, -8'sd3, -8'sd34};

  localparam sample_t LTS_RE [LTS_LEN] = '{
    8'sd40, -8'sd1, 8'sd10, 8'sd25, 8'sd5, 8'sd15, -8'sd29, -8'sd10,
    8'sd25, 8'sd14, 8'sd0, -8'sd35, 8'sd6, 8'sd15, -8'sd6, 8'sd30,
    8'sd16, 8'sd9, -8'sd15, -8'sd34, 8'sd21, 8'sd18, -8'sd15, -8'sd14,
    -8'sd9, -8'sd31, -8'sd33, 8'sd19, -8'sd1, -8'sd24, 8'sd24, 8'sd3,
    -8'sd40, 8'sd3, 8'sd24, -8'sd24, -8'sd1, 8'sd19, -8'sd33, -8'sd31,
    -8'sd9, -8'sd14, -8'sd15, 8'sd18, 8'sd21, -8'sd34, -8'sd15, 8'sd9,
    8'sd16, 8'sd30, -8'sd6, 8'sd15, 8'sd6, -8'sd35, 8'sd0, 8'sd14,
    8'sd25, -8'sd10, -8'sd29, 8'sd15, 8'sd5, 8'sd25, 8'sd10, -8'sd1};
  localparam sample_t LTS_IM [LTS_LEN] = '{
    8'sd0, -8'sd31, -8'sd28, 8'sd21, 8'sd7, -8'sd23, -8'sd14, -8'sd27,
    -8'sd7, 8'sd1, -8'sd29, -8'sd12, -8'sd15, -8'sd4, 8'sd41, -8'sd1,
    8'sd16, -8'sd25, -8'sd10, -8'sd17, -8'sd24, -8'sd4, -8'sd21, 8'sd6,
    8'sd39, 8'sd4, 8'sd5, 8'sd19, -8'sd14, 8'sd29, 8'sd27, 8'sd25,
    8'sd0, -8'sd25, -8'sd27, -8'sd29, 8'sd14, -8'sd19, -8'sd5, -8'sd4,
    -8'sd39, -8'sd6, 8'sd21, 8'sd4, 8'sd24, 8'sd17, 8'sd10, 8'sd25,
    -8'sd16, 8'sd1, -8'sd41, 8'sd4, 8'sd15, 8'sd12, 8'sd29, -8'sd1,
    8'sd7, 8'sd27, 8'sd14, 8'sd23, -8'sd7, -8'sd21, 8'sd28, 8'sd31};

endpackage

// File: rtl/preamble_rom.sv
// Combinational STS/LTS sample lookup; the STS table is addressed by the low four index bits.
module preamble_rom
  import ofdm_preamble_pkg::*;
(
  input  logic       segSel,
  input  logic [5:0] index,
  output sample_t    re,
  output sample_t    im
);

  always_comb begin
    if (segSel == SEG_STS) begin
      re = STS_RE[index[3:0]];
      im = STS_IM[index[3:0]];
    end else begin
      re = LTS_RE[index];
      im = LTS_IM[index];
    end
  end

endmodule

// File: rtl/ofdm_preamble_generator.sv
// Streams the STS / GI2 / LTS training preamble with valid/ready backpressure.
// Define PREAMBLE_WINDOW_EN to soften segment boundaries and append a half-scale LTS[0] tail sample.
module ofdm_preamble_generator
  import ofdm_preamble_pkg::*;
#(
  parameter int STS_REPS   = 10,
  parameter int LTS_REPS   = 2,
  parameter int GI2_LEN    = 32,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Start,
  output logic                  Busy,
  output logic                  OutputEnable,
  input  logic                  DataOutReady,
  output logic [DATA_WIDTH-1:0] DataOutRe,
  output logic [DATA_WIDTH-1:0] DataOutIm,
  output logic                  Done
);

`ifdef PREAMBLE_WINDOW_EN
  localparam int WIN_EXTRA = 1;
`else
  localparam int WIN_EXTRA = 0;
`endif
  localparam int STS_TOTAL = STS_REPS * STS_LEN;
  localparam int LTS_TOTAL = LTS_REPS * LTS_LEN + WIN_EXTRA;
  localparam int CNT_MAX   = (STS_TOTAL > LTS_TOTAL) ? STS_TOTAL : LTS_TOTAL;
  localparam int CNT_W     = $clog2(CNT_MAX);

  state_e           state, stateNext;
  logic [CNT_W-1:0] count, countNext;
  logic             startArmed;
  logic             accept;
  logic             prime;
  logic             loadSample;
  logic             romSeg;
  logic [5:0]       romIndex;
  sample_t          romRe, romIm;
  sample_t          sampleRe, sampleIm;

`ifdef PREAMBLE_WINDOW_EN
  function automatic logic signed [SAMPLE_W:0] widen(input sample_t v);
    return {v[SAMPLE_W-1], v};
  endfunction

  // Arithmetic shift keeps the halving rounded toward negative infinity.
  function automatic sample_t halveFloor(input logic signed [SAMPLE_W:0] x);
    return sample_t'(x >>> 1);
  endfunction
`endif

  assign accept = OutputEnable && DataOutReady;
  // First STS cycle: state has moved but the output register is not yet loaded.
  assign prime  = (state == ST_STS) && !OutputEnable;

  always_comb begin
    stateNext  = state;
    countNext  = count;
    loadSample = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Start && startArmed) begin
          stateNext = ST_STS;
          countNext = '0;
        end
      end
      ST_STS: begin
        if (prime) begin
          loadSample = 1'b1;
        end else if (accept) begin
          loadSample = 1'b1;
          if (count == CNT_W'(STS_TOTAL - 1)) begin
            stateNext = ST_GI2;
            countNext = '0;
          end else begin
            countNext = count + 1'b1;
          end
        end
      end
      ST_GI2: begin
        if (accept) begin
          loadSample = 1'b1;
          if (count == CNT_W'(GI2_LEN - 1)) begin
            stateNext = ST_LTS;
            countNext = '0;
          end else begin
            countNext = count + 1'b1;
          end
        end
      end
      ST_LTS: begin
        if (accept) begin
          loadSample = 1'b1;
          if (count == CNT_W'(LTS_TOTAL - 1)) begin
            stateNext = ST_DONE;
            countNext = '0;
          end else begin
            countNext = count + 1'b1;
          end
        end
      end
      ST_DONE: stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  // ROM is addressed by the sample about to be registered, so accepted transfers stream gap-free.
  always_comb begin
    romSeg   = (stateNext == ST_STS) ? SEG_STS : SEG_LTS;
    romIndex = countNext[5:0];
    if (stateNext == ST_GI2) romIndex = 6'(LTS_LEN - GI2_LEN) + countNext[5:0];
  end

  preamble_rom uRom (
    .segSel (romSeg),
    .index  (romIndex),
    .re     (romRe),
    .im     (romIm)
  );

  always_comb begin
    sampleRe = romRe;
    sampleIm = romIm;
`ifdef PREAMBLE_WINDOW_EN
    if (stateNext == ST_STS && countNext == '0) begin
      sampleRe = halveFloor(widen(romRe));
      sampleIm = halveFloor(widen(romIm));
    end else if (stateNext == ST_GI2 && countNext == '0) begin
      sampleRe = halveFloor(widen(STS_RE[0]) + widen(romRe));
      sampleIm = halveFloor(widen(STS_IM[0]) + widen(romIm));
    end else if (stateNext == ST_LTS && countNext == CNT_W'(LTS_TOTAL - 1)) begin
      sampleRe = halveFloor(widen(romRe));
      sampleIm = halveFloor(widen(romIm));
    end
`endif
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state        <= ST_IDLE;
      count        <= '0;
      startArmed   <= 1'b0;
      Busy         <= 1'b0;
      OutputEnable <= 1'b0;
      Done         <= 1'b0;
      DataOutRe    <= '0;
      DataOutIm    <= '0;
    end else begin
      startArmed   <= 1'b1;
      state        <= stateNext;
      count        <= countNext;
      Busy         <= (state != ST_IDLE) && (stateNext != ST_IDLE);
      OutputEnable <= (state != ST_IDLE) &&
                      (stateNext == ST_STS || stateNext == ST_GI2 || stateNext == ST_LTS);
      Done         <= (stateNext == ST_DONE);
      if (stateNext == ST_DONE) begin
        DataOutRe <= '0;
        DataOutIm <= '0;
      end else if (loadSample) begin
        DataOutRe <= DATA_WIDTH'(sampleRe);
        DataOutIm <= DATA_WIDTH'(sampleIm);
      end
    end
  end

endmodule

// File: tb/tb_ofdm_preamble_generator.sv
// Bench for ofdm_preamble_generator: reference preamble built from the 802.11a training values.
// Honours PREAMBLE_WINDOW_EN the same way the design does.
module tb_ofdm_preamble_generator;

`ifdef PREAMBLE_WINDOW_EN
  localparam int N = 321;
  localparam bit WIN = 1'b1;
`else
  localparam int N = 320;
  localparam bit WIN = 1'b0;
`endif
  localparam int STS_N = 160;
  localparam int GI2_N = 32;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       Start = 1'b0;
  logic       DataOutReady = 1'b0;
  logic       Busy, OutputEnable, Done;
  logic [7:0] DataOutRe, DataOutIm;

  int checks = 0;
  int failures = 0;
  int expRe[N], expIm[N];
  int gotRe[N], gotIm[N];
  int refRe[N], refIm[N];

  // Training symbol values in thousandths; the LTS is stored for n=0..32 and mirrored as a conjugate.
  int smRe[16] = '{46, -132, -13, 143, 92, 143, -13, -132, 46, 2, -79, -13, 0, -13, -79, 2};
  int smIm[16] = '{46, 2, -79, -13, 0, -13, -79, 2, 46, -132, -13, 143, 92, 143, -13, -132};
  int lmRe[33] = '{156, -5, 40, 97, 21, 60, -115, -38, 98, 53, 1, -137, 24, 59, -22, 119, 62,
                   37, -57, -131, 82, 70, -60, -56, -35, -122, -127, 75, -3, -92, 92, 12, -156};
  int lmIm[33] = '{0, -120, -111, 83, 28, -88, -55, -106, -26, 4, -115, -47, -59, -15, 161, -5, 62,
                   -98, -39, -65, -92, -14, -81, 22, 151, 17, 21, 74, -54, 115, 106, 98, 0};

  always #5 Clk = ~Clk;

  ofdm_preamble_generator dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .Start        (Start),
    .Busy         (Busy),
    .OutputEnable (OutputEnable),
    .DataOutReady (DataOutReady),
    .DataOutRe    (DataOutRe),
    .DataOutIm    (DataOutIm),
    .Done         (Done)
  );

  function automatic int q(int m);
    return int'(real'(m) * 0.256);
  endfunction

  function automatic int ltsRe(int n);
    return (n <= 32) ? q(lmRe[n]) : q(lmRe[64 - n]);
  endfunction

  function automatic int ltsIm(int n);
    return (n <= 32) ? q(lmIm[n]) : -q(lmIm[64 - n]);
  endfunction

  task automatic buildModel();
    for (int i = 0; i < N; i++) begin
      if (i < STS_N) begin
        expRe[i] = q(smRe[i % 16]);
        expIm[i] = q(smIm[i % 16]);
      end else if (i < STS_N + GI2_N) begin
        expRe[i] = ltsRe(64 - GI2_N + (i - STS_N));
        expIm[i] = ltsIm(64 - GI2_N + (i - STS_N));
      end else begin
        expRe[i] = ltsRe((i - STS_N - GI2_N) % 64);
        expIm[i] = ltsIm((i - STS_N - GI2_N) % 64);
      end
    end
    if (WIN) begin
      expRe[0] = expRe[0] >>> 1;
      expIm[0] = expIm[0] >>> 1;
      expRe[STS_N] = (q(smRe[0]) + expRe[STS_N]) >>> 1;
      expIm[STS_N] = (q(smIm[0]) + expIm[STS_N]) >>> 1;
      expRe[N-1] = expRe[N-1] >>> 1;
      expIm[N-1] = expIm[N-1] >>> 1;
    end
  endtask

  // One preamble from Start to idle; optional random backpressure, stray Starts and mid-stream reset.
  task automatic runStream(input bit randReady, input bit glitch, input int abortAt, input string name);
    int idx;
    int cyc;
    bit rdy;
    idx = 0;
    cyc = 0;
    @(negedge Clk);
    Start = 1'b1;
    DataOutReady = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    checks++;
    if (OutputEnable !== 1'b0 || Busy !== 1'b0)
      $display("FAIL %s latency: oe=%b busy=%b one cycle after start, want oe=0 busy=0",
               name, OutputEnable, Busy);
    @(negedge Clk);
    while (idx < N) begin
      if (cyc > 4000) begin
        failures++;
        $display("FAIL %s timeout: accepted %0d samples, want %0d", name, idx, N);
        return;
      end
      checks++;
      if (OutputEnable !== 1'b1 || Busy !== 1'b1 || Done !== 1'b0) begin
        failures++;
        $display("FAIL %s ctrl[%0d]: oe=%b busy=%b done=%b want 1 1 0",
                 name, idx, OutputEnable, Busy, Done);
      end
      checks++;
      if ($signed(DataOutRe) !== 8'(expRe[idx]) || $signed(DataOutIm) !== 8'(expIm[idx])) begin
        failures++;
        $display("FAIL %s data[%0d]: got re=%0d im=%0d want re=%0d im=%0d",
                 name, idx, $signed(DataOutRe), $signed(DataOutIm), expRe[idx], expIm[idx]);
      end
      if (idx == abortAt) begin
        #2 Rst_n = 1'b0;
        #1;
        checks++;
        if (OutputEnable !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0 ||
            DataOutRe !== 8'd0 || DataOutIm !== 8'd0) begin
          failures++;
          $display("FAIL %s async_reset: oe=%b busy=%b done=%b re=%0d im=%0d want all 0",
                   name, OutputEnable, Busy, Done, DataOutRe, DataOutIm);
        end
        repeat (3) begin
          @(negedge Clk);
          checks++;
          if (Done !== 1'b0 || OutputEnable !== 1'b0) begin
            failures++;
            $display("FAIL %s reset_hold: done=%b oe=%b want 0 0", name, Done, OutputEnable);
          end
        end
        Rst_n = 1'b1;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (3) begin
          checks++;
          if (Busy !== 1'b0 || OutputEnable !== 1'b0 || Done !== 1'b0) begin
            failures++;
            $display("FAIL %s start_at_release: busy=%b oe=%b done=%b want 0 0 0",
                     name, Busy, OutputEnable, Done);
          end
          @(negedge Clk);
        end
        return;
      end
      rdy = randReady ? ($urandom_range(0, 2) != 0) : 1'b1;
      Start = glitch && (idx == 5 || idx == 319);
      DataOutReady = rdy;
      if (rdy) begin
        gotRe[idx] = int'($signed(DataOutRe));
        gotIm[idx] = int'($signed(DataOutIm));
        idx++;
      end
      @(negedge Clk);
      cyc++;
    end
    Start = 1'b0;
    checks++;
    if (OutputEnable !== 1'b0 || Done !== 1'b1 || Busy !== 1'b1) begin
      failures++;
      $display("FAIL %s done_cycle: oe=%b done=%b busy=%b want 0 1 1", name, OutputEnable, Done, Busy);
    end
    Start = glitch;
    @(negedge Clk);
    Start = 1'b0;
    repeat (4) begin
      checks++;
      if (Busy !== 1'b0 || OutputEnable !== 1'b0 || Done !== 1'b0) begin
        failures++;
        $display("FAIL %s idle_after: busy=%b oe=%b done=%b want 0 0 0", name, Busy, OutputEnable, Done);
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    Start = 1'b0;
    DataOutReady = 1'b0;
    repeat (3) @(negedge Clk);
    checks++;
    if (Busy !== 1'b0 || OutputEnable !== 1'b0 || Done !== 1'b0 || DataOutRe !== 8'd0 || DataOutIm !== 8'd0) begin
      failures++;
      $display("FAIL reset_state: busy=%b oe=%b done=%b re=%0d im=%0d want all 0",
               Busy, OutputEnable, Done, DataOutRe, DataOutIm);
    end
    Rst_n = 1'b1;
    @(negedge Clk);
    checks++;
    if (Busy !== 1'b0 || OutputEnable !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: busy=%b oe=%b want 0 0", Busy, OutputEnable);
    end
  endtask

  task automatic test_nominal();
    runStream(1'b0, 1'b0, -1, "nominal");
    for (int i = 0; i < N; i++) begin
      refRe[i] = gotRe[i];
      refIm[i] = gotIm[i];
    end
    checks++;
    if (gotRe[0] !== (WIN ? 6 : 12) || gotIm[0] !== (WIN ? 6 : 12)) begin
      failures++;
      $display("FAIL first_sample: got %0d,%0d want %0d,%0d", gotRe[0], gotIm[0], WIN ? 6 : 12, WIN ? 6 : 12);
    end
    checks++;
    if (gotRe[16] !== 12 || gotIm[16] !== 12) begin
      failures++;
      $display("FAIL sample16: got %0d,%0d want 12,12", gotRe[16], gotIm[16]);
    end
    checks++;
    if (gotRe[160] !== (WIN ? -14 : -40) || gotIm[160] !== (WIN ? 6 : 0)) begin
      failures++;
      $display("FAIL sample160: got %0d,%0d want %0d,%0d", gotRe[160], gotIm[160], WIN ? -14 : -40, WIN ? 6 : 0);
    end
    checks++;
    if (gotRe[192] !== 40 || gotIm[192] !== 0 || gotRe[256] !== 40 || gotIm[256] !== 0) begin
      failures++;
      $display("FAIL lts0_samples: got %0d,%0d and %0d,%0d want 40,0", gotRe[192], gotIm[192], gotRe[256], gotIm[256]);
    end
    checks++;
    if (gotRe[N-1] !== (WIN ? 20 : -1) || gotIm[N-1] !== (WIN ? 0 : 31)) begin
      failures++;
      $display("FAIL last_sample: got %0d,%0d want %0d,%0d", gotRe[N-1], gotIm[N-1], WIN ? 20 : -1, WIN ? 0 : 31);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    for (int i = 0; i < N; i++) begin
      gotRe[i] = 999;
      gotIm[i] = 999;
    end
    runStream(1'b1, 1'b0, -1, "backpressure");
    for (int i = 0; i < N; i++)
      if (gotRe[i] != refRe[i] || gotIm[i] != refIm[i]) bad++;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL backpressure_vs_gapfree: %0d differing samples, want 0", bad);
    end
  endtask

  task automatic test_start_ignored();
    runStream(1'b0, 1'b1, -1, "start_ignored");
  endtask

  task automatic test_restart();
    runStream(1'b0, 1'b0, -1, "restart");
  endtask

  task automatic test_reset_abort();
    runStream(1'b1, 1'b0, 100, "abort");
    runStream(1'b1, 1'b0, -1, "after_abort");
  endtask

  initial begin
    buildModel();
    test_reset();
    test_nominal();
    test_backpressure();
    test_start_ignored();
    test_restart();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
